interp_seq_ctrl: RTL and testbench
==================================

Name: interp_seq_ctrl

Overview:
- FSM sequencer for the two-lane (real/imag) channel-interpolation datapath.
- On a start pulse it drives every control input of that datapath: the adder-operand mux selects s1a, s1b, s2a and s2b; the output mux selects s_h1 and s_h2; the estimate-swap select sel_est; and the register enables en_reg_E, en_reg_2E and en_reg_5E.
- It preloads the intermediate registers, then emits 12 interpolated subcarriers as 6 output pairs under a valid/ready handshake.
- It sits between the NRS estimator, whose E1..E4 are held stable while busy=1, and the equalizer.

Parameters:
- NUM_STEPS, 6, number of output pairs per run (12 subcarriers). Only the default has a defined schedule table.
- IDX_W, 4, width of h_idx.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; E1..E4 are valid and stay stable until done
- cell_shift  in  1  NRS frequency-shift parity; latched into sel_est at accepted start
- out_ready  in  1  equalizer accepts the current output pair
- s1a  out  3  adder1 operand-A select
- s1b  out  3  adder1 operand-B select
- s2a  out  3  adder2 operand-A select
- s2b  out  3  adder2 operand-B select
- s_h1  out  2  h_eqlz_1 output select
- s_h2  out  2  h_eqlz_2 output select
- sel_est  out  1  estimate ordering select
- en_reg_E  out  1  load reg_E from adder2
- en_reg_2E  out  1  load reg_2E from adder1
- en_reg_5E  out  1  load reg_5E from adder1
- h_valid  out  1  h_eqlz_1/h_eqlz_2 hold a valid pair
- h_idx  out  IDX_W  subcarrier index of h_eqlz_1; h_eqlz_2 is h_idx+1
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last pair is accepted

Behaviour:
- Reset values: all outputs 0, state IDLE, step counter 0, sel_est 0.
- States: IDLE -> PRE0 -> PRE1 -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches sel_est<=cell_shift and goes to PRE0.
  - start is ignored in every state other than IDLE.
- PRE0 (1 cycle):
  - s1a=1, s1b=1 (adder1 = E2+E2); s2a=0, s2b=0 (adder2 = E1).
  - en_reg_2E=1, en_reg_E=1.
  - Next state PRE1.
- PRE1 (1 cycle):
  - s1a=2, s1b=2 (adder1 = reg_2E+reg_2E+...; datapath code for 5E).
  - en_reg_5E=1.
  - Next state RUN, step=0.
- RUN:
  - h_valid=1 for the whole state.
  - Step codes as s1a,s1b,s2a,s2b,s_h1,s_h2:
    - step0: 0,0,4,0,0,1
    - step1: 1,1,1,1,2,3
    - step2: 2,2,2,2,2,3
    - step3: 3,3,3,2,1,2
    - step4: 4,3,3,3,2,3
    - step5: 4,4,4,3,3,0
  - h_idx = 2*step.
  - Handshake: the step advances only on a cycle with h_valid && out_ready.
  - If out_ready=0 the step holds and every select and h_idx stays stable; they may not glitch.
  - en_reg_* are 0 throughout RUN.
  - Acceptance at step NUM_STEPS-1 goes to DONE.
- DONE (1 cycle): done=1, busy=0, h_valid=0; next state IDLE.
- busy=1 in PRE0, PRE1 and RUN.
- Latency: first h_valid appears 3 cycles after the start edge. Minimum run is 2+6+1 = 9 cycles with out_ready tied high.
- All control outputs are registered, and they are decoded from next state and step so they align with the state cycle.
- Outside PRE0, PRE1 and RUN every select is 0.
- Reset mid-run forces IDLE immediately with all outputs 0. No pair is emitted after reset deasserts until a new start.
- start in the same cycle as DONE is ignored. start is accepted on the following IDLE cycle.

Optional Feature:
- Macro INTERP_SEQ_ERR_EN.
- When defined, add output err (1 bit, reset 0):
  - Set sticky when start=1 arrives while busy=1.
  - Set sticky when out_ready stays 0 for more than 15 consecutive RUN cycles.
  - Cleared only by reset.
- When undefined, the err port is absent and these events are silently ignored.

Test Plan:
1. Reset, then start=1 with cell_shift=1 and out_ready=1. Required: PRE0 at cycle 1 (en_reg_2E=en_reg_E=1), PRE1 at cycle 2 (en_reg_5E=1). h_valid for cycles 3-8 with h_idx 0,2,4,6,8,10 and the step-table codes. done pulses at cycle 9. sel_est=1 throughout.
2. out_ready toggling 1,0,0,1,... during RUN. Required: each step is held exactly while out_ready=0 and codes stay stable. Exactly 6 acceptances occur before done.
3. start pulsed during PRE1 and during RUN step 3. Required: ignored, with run length and codes unchanged. With INTERP_SEQ_ERR_EN defined, err=1 and stays 1.
4. rst asserted at RUN step 2. Required: all outputs 0 asynchronously. After release, outputs stay idle until a new start; that run begins again at h_idx=0.
5. start in the DONE cycle, then again one cycle later. Required: the first is ignored, the second begins PRE0 on the next cycle.
6. With INTERP_SEQ_ERR_EN, out_ready=0 for 16 RUN cycles. Required: err rises on the 16th stalled cycle and h_idx is still 0.

Source files
------------

// File: rtl/interp_seq_ctrl.sv
// Control sequencer for the two-lane channel-interpolation datapath: preloads E/2E/5E, then
// emits six subcarrier pairs under valid/ready. Define INTERP_SEQ_ERR_EN to add a sticky err output.
module interp_seq_ctrl #(
  parameter int unsigned NUM_STEPS = 6,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cell_shift,
  input  logic             out_ready,
  output logic [2:0]       s1a,
  output logic [2:0]       s1b,
  output logic [2:0]       s2a,
  output logic [2:0]       s2b,
  output logic [1:0]       s_h1,
  output logic [1:0]       s_h2,
  output logic             sel_est,
  output logic             en_reg_E,
  output logic             en_reg_2E,
  output logic             en_reg_5E,
  output logic             h_valid,
  output logic [IDX_W-1:0] h_idx,
  output logic             busy,
`ifdef INTERP_SEQ_ERR_EN
  output logic             err,
`endif
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StPre0, StPre1, StRun, StDone} state_e;

  localparam int unsigned StepW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(NUM_STEPS - 1);

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;

  logic [15:0]      code_d;
  logic [2:0]       en_d;
  logic             hv_d, busy_d, done_d, sel_d;
  logic [IDX_W-1:0] idx_d;

  // Adder/output select codes per RUN step: {s1a, s1b, s2a, s2b, s_h1, s_h2}
  function automatic logic [15:0] step_code(input logic [StepW-1:0] s);
    case (int'(s))
      0:       return {3'd0, 3'd0, 3'd4, 3'd0, 2'd0, 2'd1};
      1:       return {3'd1, 3'd1, 3'd1, 3'd1, 2'd2, 2'd3};
      2:       return {3'd2, 3'd2, 3'd2, 3'd2, 2'd2, 2'd3};
      3:       return {3'd3, 3'd3, 3'd3, 3'd2, 2'd1, 2'd2};
      4:       return {3'd4, 3'd3, 3'd3, 3'd3, 2'd2, 2'd3};
      5:       return {3'd4, 3'd4, 3'd4, 3'd3, 2'd3, 2'd0};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      StIdle: if (start) state_d = StPre0;
      StPre0: state_d = StPre1;
      StPre1: begin
        state_d = StRun;
        step_d  = '0;
      end
      StRun: begin
        if (out_ready) begin
          if (step_q == LastStep) begin
            state_d = StDone;
            step_d  = '0;
          end else begin
            step_d = step_q + StepW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registered value lines up with that state.
  always_comb begin
    code_d = '0;
    en_d   = '0;
    hv_d   = 1'b0;
    idx_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    sel_d  = (state_q == StIdle && start) ? cell_shift : sel_est;
    case (state_d)
      StPre0: begin
        code_d = {3'd1, 3'd1, 3'd0, 3'd0, 2'd0, 2'd0};
        en_d   = 3'b110;
        busy_d = 1'b1;
      end
      StPre1: begin
        code_d = {3'd2, 3'd2, 3'd0, 3'd0, 2'd0, 2'd0};
        en_d   = 3'b001;
        busy_d = 1'b1;
      end
      StRun: begin
        code_d = step_code(step_d);
        hv_d   = 1'b1;
        idx_d  = IDX_W'({step_d, 1'b0});
        busy_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      {s1a, s1b, s2a, s2b, s_h1, s_h2} <= '0;
      {en_reg_E, en_reg_2E, en_reg_5E} <= '0;
      sel_est <= 1'b0;
      h_valid <= 1'b0;
      h_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      {s1a, s1b, s2a, s2b, s_h1, s_h2} <= code_d;
      {en_reg_E, en_reg_2E, en_reg_5E} <= en_d;
      sel_est <= sel_d;
      h_valid <= hv_d;
      h_idx   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

`ifdef INTERP_SEQ_ERR_EN
  logic [3:0] stall_q;

  // stall_q counts earlier consecutive stalled RUN cycles; the 16th stall trips err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      err     <= 1'b0;
    end else begin
      if (start && busy) err <= 1'b1;
      if (state_q == StRun && !out_ready) begin
        if (stall_q == 4'd15) err <= 1'b1;
        else                  stall_q <= stall_q + 4'd1;
      end else begin
        stall_q <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_interp_seq_ctrl.sv
// Directed bench for interp_seq_ctrl with a scoreboard of expected output pairs.
module tb_interp_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, cell_shift, out_ready;
  logic [2:0] s1a, s1b, s2a, s2b;
  logic [1:0] s_h1, s_h2;
  logic       sel_est, en_reg_E, en_reg_2E, en_reg_5E, h_valid, busy, done;
  logic [3:0] h_idx;
`ifdef INTERP_SEQ_ERR_EN
  logic       err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_run;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] code;
    logic        sel;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] tbl [6] = '{
    {3'd0, 3'd0, 3'd4, 3'd0, 2'd0, 2'd1},
    {3'd1, 3'd1, 3'd1, 3'd1, 2'd2, 2'd3},
    {3'd2, 3'd2, 3'd2, 3'd2, 2'd2, 2'd3},
    {3'd3, 3'd3, 3'd3, 3'd2, 2'd1, 2'd2},
    {3'd4, 3'd3, 3'd3, 3'd3, 2'd2, 2'd3},
    {3'd4, 3'd4, 3'd4, 3'd3, 2'd3, 2'd0}
  };

  interp_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cell_shift(cell_shift),
    .out_ready (out_ready),
    .s1a       (s1a),
    .s1b       (s1b),
    .s2a       (s2a),
    .s2b       (s2b),
    .s_h1      (s_h1),
    .s_h2      (s_h2),
    .sel_est   (sel_est),
    .en_reg_E  (en_reg_E),
    .en_reg_2E (en_reg_2E),
    .en_reg_5E (en_reg_5E),
    .h_valid   (h_valid),
    .h_idx     (h_idx),
    .busy      (busy),
`ifdef INTERP_SEQ_ERR_EN
    .err       (err),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Packed view: code[26:11] sel[10] en{E,2E,5E}[9:7] valid[6] idx[5:2] busy[1] done[0]
  function automatic logic [26:0] outs();
    return {s1a, s1b, s2a, s2b, s_h1, s_h2, sel_est, en_reg_E, en_reg_2E, en_reg_5E,
            h_valid, h_idx, busy, done};
  endfunction

  function automatic logic [26:0] mk(logic [15:0] c, logic s, logic [2:0] en, logic hv,
                                     logic [3:0] idx, logic b, logic d);
    return {c, s, en, hv, idx, b, d};
  endfunction

  function automatic logic [26:0] nosel(logic [26:0] o);
    return o & ~(27'd1 << 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // One clock: compare any presented pair against the scoreboard head, pop on acceptance.
  task automatic tick(input logic rdy);
    exp_t e;
    out_ready = rdy;
    if (h_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected pair", {31'd0, h_valid}, 32'd0);
      end else begin
        e = exp_q[0];
        chk("pair idx", {28'd0, h_idx}, {28'd0, e.idx});
        chk("pair code", {16'd0, s1a, s1b, s2a, s2b, s_h1, s_h2}, {16'd0, e.code});
        chk("pair sel", {31'd0, sel_est}, {31'd0, e.sel});
        chk("run enables", {29'd0, en_reg_E, en_reg_2E, en_reg_5E}, 32'd0);
        if (rdy) void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Starts a run from IDLE and leaves the bench at RUN step 0. poke pulses start during PRE1.
  task automatic start_run(input logic cs, input logic poke);
    start      = 1'b1;
    cell_shift = cs;
    for (int k = 0; k < 6; k++) exp_q.push_back('{idx: 4'(2 * k), code: tbl[k], sel: cs});
    tick(1'b1);
    chk("pre0 outputs", outs(), mk({3'd1, 3'd1, 10'd0}, cs, 3'b110, 1'b0, 4'd0, 1'b1, 1'b0));
    tick(1'b1);
    chk("pre1 outputs", outs(), mk({3'd2, 3'd2, 10'd0}, cs, 3'b001, 1'b0, 4'd0, 1'b1, 1'b0));
    if (poke) begin
      start      = 1'b1;
      cell_shift = ~cs;
    end
    tick(1'b1);
  endtask

  // Runs until done (mode 0: ready high, mode 1: ready pattern 1,0,0); n = cycles taken.
  task automatic drain(input int mode, input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick(mode == 0 ? 1'b1 : ((i % 3) == 0));
      n++;
    end
    chk("done pulse", {31'd0, done}, 32'd1);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    chk("done outputs", nosel(outs()), 32'd1);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    cell_shift = 1'b0;
    out_ready  = 1'b0;
    #12;
    chk("reset outputs", outs(), 32'd0);
`ifdef INTERP_SEQ_ERR_EN
    chk("reset err", {31'd0, err}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic run, ready always high: six pairs at cycles 3..8, done at cycle 9.
    start_run(1'b1, 1'b0);
    drain(0, 20, n_run);
    chk("t1 run length", n_run, 32'd6);
    tick(1'b1);
    chk("t1 idle after done", nosel(outs()), 32'd0);

    // Ready toggling: steps must hold while stalled.
    start_run(1'b0, 1'b0);
    drain(1, 40, n_run);
    chk("t2 run length", n_run, 32'd16);
    tick(1'b1);

    // Stray starts during PRE1 and RUN step 3 are ignored.
    start_run(1'b0, 1'b1);
    tick(1'b1);
    tick(1'b1);
    tick(1'b1);
    chk("t3 at step3", {28'd0, h_idx}, 32'd6);
    start      = 1'b1;
    cell_shift = 1'b1;
    tick(1'b1);
    drain(0, 10, n_run);
    chk("t3 remaining length", n_run, 32'd2);
`ifdef INTERP_SEQ_ERR_EN
    chk("t3 err sticky", {31'd0, err}, 32'd1);
`endif
    tick(1'b1);

    // Asynchronous reset at RUN step 2.
    start_run(1'b1, 1'b0);
    tick(1'b1);
    tick(1'b1);
    chk("t4 at step2", {28'd0, h_idx}, 32'd4);
    rst = 1'b0;
    #1;
    chk("t4 async reset", outs(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("t4 idle after reset", outs(), 32'd0);
    end
    start_run(1'b0, 1'b0);
    drain(0, 20, n_run);
    chk("t4 rerun length", n_run, 32'd6);

    // Start in the DONE cycle is dropped; the next cycle's start is taken.
    tick(1'b1);
    start_run(1'b1, 1'b0);
    drain(0, 20, n_run);
    start      = 1'b1;
    cell_shift = 1'b0;
    tick(1'b1);
    chk("t5 start in done ignored", nosel(outs()), 32'd0);
    start_run(1'b0, 1'b0);
    drain(0, 20, n_run);
    chk("t5 run length", n_run, 32'd6);
    tick(1'b1);

    // Long stall at step 0: index and codes must hold.
    start_run(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0);
    chk("t6 idx held", {28'd0, h_idx}, 32'd0);
    chk("t6 still valid", {31'd0, h_valid}, 32'd1);
`ifdef INTERP_SEQ_ERR_EN
    chk("t6 err", {31'd0, err}, 32'd1);
`endif
    drain(0, 20, n_run);
    chk("t6 run length", n_run, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
